time_counter_master: RTL and testbench
======================================

# time_counter_master

Bus initiator that drives the timer peripheral's native interface (`addr`, `enable`, `data_in`, `ready`, `data_out`) on behalf of a measurement client. On `start` it soft-resets the timer. While running it polls the count to track wrap-arounds. On `stop` it performs a final read and returns the elapsed cycle count, extended with a wrap count. It sits between a control FSM or testbench harness and one timer instance.

## Interface
- `COUNTER_WIDTH`, 32, width of the timer count and data buses
- `WRAP_W`, 8, width of the wrap-around counter
- `POLL_PERIOD`, 1024, cycles between background polls in RUN; minimum 4
- `TIMEOUT`, 16, maximum cycles to wait for `t_ready` after a request
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock domain; synchronous, active-high
- `start`  in  1  single-cycle pulse; begins a measurement
- `stop`  in  1  single-cycle pulse; ends the measurement
- `busy`  out  1  high from accepted `start` until result or error
- `result_valid`  out  1  one-cycle pulse when `result` is updated
- `result`  out  WRAP_W+COUNTER_WIDTH  {wraps, final count}; held until next update
- `error`  out  1  sticky; set on timeout or wrap saturation, cleared by accepted `start`
- `t_addr`  out  1  timer register select: 0 = count (read), 1 = soft reset (write)
- `t_enable`  out  1  single-cycle request strobe
- `t_data_in`  out  COUNTER_WIDTH  write data; bit 0 = 1 on reset request, 0 otherwise
- `t_ready`  in  1  timer acknowledge; nominally one cycle after `t_enable`
- `t_data_out`  in  COUNTER_WIDTH  live timer count; sampled in the cycle `t_ready` is high

## Operation
- States: IDLE, RST_REQ, RST_WAIT, RUN, RD_REQ, RD_WAIT, FIN_REQ, FIN_WAIT, ERR.
- IDLE: on `start`, clear `error`, clear wraps and last-value, then go to RST_REQ. `stop` is ignored in IDLE.
- RST_REQ: assert `t_enable`=1, `t_addr`=1, `t_data_in`=1 for exactly one cycle, then go to RST_WAIT.
- RST_WAIT: on `t_ready`, set last-value to 0, clear the poll counter, and go to RUN.
- RUN: the poll counter increments each cycle.
  - At `POLL_PERIOD-1`, go to RD_REQ.
  - On `stop` (or a pending stop), go to FIN_REQ.
- RD_REQ / FIN_REQ: assert `t_enable`=1, `t_addr`=0, `t_data_in`=0 for one cycle.
- RD_WAIT / FIN_WAIT: on `t_ready`, capture `t_data_out`.
  - If the captured value is less than last-value, increment wraps.
  - Then update last-value.
  - RD_WAIT returns to RUN with the poll counter cleared, or goes to FIN_REQ if a stop is pending.
  - FIN_WAIT loads `result`, pulses `result_valid`, and goes to IDLE.
- A `stop` that arrives outside RUN while busy sets stop-pending. Stop-pending is serviced as soon as the current transaction completes.
- `start` while busy is ignored.
- Wraps saturate at all-ones. An increment attempted at saturation sets `error`, and the measurement continues.
- Timeout: a wait counter clears on each request. If `t_ready` has not been seen after `TIMEOUT` cycles in any WAIT state:
  - go to ERR, set `error`, drop `busy`;
  - return to IDLE on the next cycle with no `result_valid`.
- `t_ready` is ignored outside WAIT states.

## Timing
- Reset values: `busy`=0, `result_valid`=0, `result`=0, `error`=0, `t_enable`=0, `t_addr`=0, `t_data_in`=0. State is IDLE, wraps and last-value are 0, stop-pending is cleared.
- `start` at cycle N:
  - `busy`=1 and state RST_REQ at N+1;
  - `t_enable` high during N+1;
  - with a one-cycle `t_ready`, RUN from N+3.
- `stop` accepted in RUN at cycle M:
  - FIN_REQ at M+1;
  - `t_ready` at M+2;
  - `result_valid` and new `result` at M+3;
  - `busy`=0 at M+3.
- `t_enable` is never high on two consecutive cycles. At most one request is outstanding.
- All outputs are registered.
- Reset asserted mid-measurement returns every output to its reset value on the next edge. No request is issued in that cycle.
- Wrap detection is valid only if the timer wraps at most once per `POLL_PERIOD` plus request latency.

## Test plan
- **Basic measurement:** `start`, then `stop` 100 cycles after RUN entry, with a timer model acking in 1 cycle. Required: one reset write with `t_addr`=1, `t_data_in`=1; `result_valid` once; `result` = {0, expected count}; `error`=0.
- **Wrap tracking:** `COUNTER_WIDTH`=8, `POLL_PERIOD`=64, run 600 cycles. Required: wraps field = 2 (600/256 rounded down), low byte = count mod 256; poll reads evenly spaced.
- **Stop during poll:** assert `stop` in RD_WAIT. Required: the poll completes, one FIN read follows, and a single `result_valid`.
- **Timeout:** the timer model never asserts `t_ready` after the reset write. Required: `error`=1 exactly `TIMEOUT` cycles later, `busy`=0, no `result_valid`; a new `start` clears `error`.
- **Saturation:** `WRAP_W`=2, `COUNTER_WIDTH`=4, `POLL_PERIOD`=4, long run. Required: wraps stick at 3, `error`=1, and the result is still delivered on `stop`.
- **Ignored inputs:** `start` while busy, `stop` in IDLE, and `rst` asserted mid-RUN. Required: no extra requests; after reset all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/time_counter_master.sv
// time_counter_master
// Bus initiator for one timer peripheral. A start soft-resets the timer, the
// count is polled in the background to detect wrap-arounds, and a stop takes
// a final reading and returns {wraps, count}.
//
// Timer handshake: the master raises t_enable for exactly one cycle together
// with t_addr/t_data_in, then waits in a WAIT state for t_ready. t_data_out is
// sampled only in the cycle t_ready is high. Only one request is ever in
// flight, and t_ready outside a WAIT state is ignored.
module time_counter_master #(
  parameter int COUNTER_WIDTH = 32,
  parameter int WRAP_W        = 8,
  parameter int POLL_PERIOD   = 1024,  // at least 4
  parameter int TIMEOUT       = 16     // at least 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  output logic                            busy,
  output logic                            result_valid,
  output logic [WRAP_W+COUNTER_WIDTH-1:0] result,
  output logic                            error,
  output logic                            t_addr,
  output logic                            t_enable,
  output logic [COUNTER_WIDTH-1:0]        t_data_in,
  input  logic                            t_ready,
  input  logic [COUNTER_WIDTH-1:0]        t_data_out,
  output logic [3:0]                      state_dbg
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RST_REQ  = 4'd1,
    S_RST_WAIT = 4'd2,
    S_RUN      = 4'd3,
    S_RD_REQ   = 4'd4,
    S_RD_WAIT  = 4'd5,
    S_FIN_REQ  = 4'd6,
    S_FIN_WAIT = 4'd7,
    S_ERR      = 4'd8
  } state_t;

  state_t                   state;
  logic [WRAP_W-1:0]        wraps;
  logic [COUNTER_WIDTH-1:0] last_val;
  logic [PW-1:0]            poll_cnt;
  logic [TW-1:0]            wait_cnt;
  logic                     stop_pend;

  logic                     wrap_hit;
  logic                     sat_hit;
  logic [WRAP_W-1:0]        wraps_next;

  assign state_dbg = state;

  // Wrap detection on the sampled count; saturates at all-ones and flags overflow.
  always_comb begin
    wrap_hit   = 1'b0;
    sat_hit    = 1'b0;
    wraps_next = wraps;
    wrap_hit   = (t_data_out < last_val);
    sat_hit    = wrap_hit && (&wraps);
    if (wrap_hit && !(&wraps)) begin
      wraps_next = wraps + 1'b1;
    end
  end

  // Control FSM; all bus and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      error        <= 1'b0;
      t_enable     <= 1'b0;
      t_addr       <= 1'b0;
      t_data_in    <= '0;
      wraps        <= '0;
      last_val     <= '0;
      poll_cnt     <= '0;
      wait_cnt     <= '0;
      stop_pend    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      t_enable     <= 1'b0;
      t_addr       <= 1'b0;
      t_data_in    <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            error     <= 1'b0;
            wraps     <= '0;
            last_val  <= '0;
            stop_pend <= 1'b0;
            busy      <= 1'b1;
            t_enable  <= 1'b1;
            t_addr    <= 1'b1;
            t_data_in <= COUNTER_WIDTH'(1);
            state     <= S_RST_REQ;
          end
        end

        S_RST_REQ, S_RD_REQ: begin
          if (stop) stop_pend <= 1'b1;
          wait_cnt <= TW'(1);
          state    <= (state == S_RST_REQ) ? S_RST_WAIT : S_RD_WAIT;
        end

        S_FIN_REQ: begin
          wait_cnt <= TW'(1);
          state    <= S_FIN_WAIT;
        end

        S_RUN: begin
          if (stop || stop_pend) begin
            stop_pend <= 1'b0;
            t_enable  <= 1'b1;
            state     <= S_FIN_REQ;
          end else if (poll_cnt == POLL_LAST) begin
            t_enable <= 1'b1;
            state    <= S_RD_REQ;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end

        S_RST_WAIT, S_RD_WAIT, S_FIN_WAIT: begin
          if (t_ready) begin
            if (state == S_RST_WAIT) begin
              if (stop) stop_pend <= 1'b1;
              last_val <= '0;
              poll_cnt <= '0;
              state    <= S_RUN;
            end else begin
              wraps    <= wraps_next;
              last_val <= t_data_out;
              if (sat_hit) error <= 1'b1;
              if (state == S_FIN_WAIT) begin
                result       <= {wraps_next, t_data_out};
                result_valid <= 1'b1;
                busy         <= 1'b0;
                state        <= S_IDLE;
              end else if (stop || stop_pend) begin
                stop_pend <= 1'b0;
                t_enable  <= 1'b1;
                state     <= S_FIN_REQ;
              end else begin
                poll_cnt <= '0;
                state    <= S_RUN;
              end
            end
          end else begin
            if (stop && state != S_FIN_WAIT) stop_pend <= 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              error     <= 1'b1;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
              state     <= S_ERR;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end

        S_ERR: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_counter_master.sv
// Directed bench for time_counter_master: instance a (8-bit count, poll every
// 64 cycles) covers measurement, wrap tracking, stop during poll, timeout and
// ignored inputs; instance b (4-bit count, 2-bit wraps) covers saturation.
module tb_time_counter_master;

  localparam int CW = 8, WW = 8, PP = 64, TO = 16;
  localparam int SCW = 4, SWW = 2, SPP = 4;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_RST_REQ = 4'd1, ST_RUN = 4'd3;
  localparam logic [3:0] ST_RD_WAIT = 4'd5, ST_FIN_REQ = 4'd6, ST_ERR = 4'd8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a
  logic             start = 1'b0, stop = 1'b0;
  logic             busy, result_valid, error, t_addr, t_enable;
  logic [WW+CW-1:0] result;
  logic [CW-1:0]    t_data_in;
  logic             t_ready = 1'b0;
  logic [CW-1:0]    tm_cnt = '0;
  logic [3:0]       state_dbg;
  logic             ack_en = 1'b1;

  // instance b
  logic               s_start = 1'b0, s_stop = 1'b0;
  logic               s_busy, s_result_valid, s_error, s_t_addr, s_t_enable;
  logic [SWW+SCW-1:0] s_result;
  logic [SCW-1:0]     s_t_data_in;
  logic               s_t_ready = 1'b0;
  logic [SCW-1:0]     s_tm_cnt = '0;
  logic [3:0]         s_state_dbg;

  time_counter_master #(.COUNTER_WIDTH(CW), .WRAP_W(WW), .POLL_PERIOD(PP), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(busy),
    .result_valid(result_valid), .result(result), .error(error),
    .t_addr(t_addr), .t_enable(t_enable), .t_data_in(t_data_in),
    .t_ready(t_ready), .t_data_out(tm_cnt), .state_dbg(state_dbg)
  );

  time_counter_master #(.COUNTER_WIDTH(SCW), .WRAP_W(SWW), .POLL_PERIOD(SPP), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .busy(s_busy),
    .result_valid(s_result_valid), .result(s_result), .error(s_error),
    .t_addr(s_t_addr), .t_enable(s_t_enable), .t_data_in(s_t_data_in),
    .t_ready(s_t_ready), .t_data_out(s_tm_cnt), .state_dbg(s_state_dbg)
  );

  // timer models: free-running count, soft reset on write, ack one cycle later
  always @(posedge clk) begin
    t_ready <= t_enable && ack_en;
    if (t_enable && t_addr && t_data_in[0]) tm_cnt <= '0;
    else tm_cnt <= tm_cnt + 1'b1;
  end

  always @(posedge clk) begin
    s_t_ready <= s_t_enable;
    if (s_t_enable && s_t_addr && s_t_data_in[0]) s_tm_cnt <= '0;
    else s_tm_cnt <= s_tm_cnt + 1'b1;
  end

  // bus monitors
  int cyc = 0, req_cnt = 0, rst_wr_cnt = 0, rv_cnt = 0, b2b_cnt = 0;
  int s_rv_cnt = 0, s_b2b_cnt = 0;
  logic prev_en = 1'b0, s_prev_en = 1'b0;
  int rd_times[$];

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    prev_en   <= t_enable;
    s_prev_en <= s_t_enable;
    if (t_enable) req_cnt <= req_cnt + 1;
    if (t_enable && t_addr && t_data_in == CW'(1)) rst_wr_cnt <= rst_wr_cnt + 1;
    if (t_enable && !t_addr) rd_times.push_back(cyc);
    if (result_valid) rv_cnt <= rv_cnt + 1;
    if (t_enable && prev_en) b2b_cnt <= b2b_cnt + 1;
    if (s_result_valid) s_rv_cnt <= s_rv_cnt + 1;
    if (s_t_enable && s_prev_en) s_b2b_cnt <= s_b2b_cnt + 1;
  end

  // scoreboard counters
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start_a();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop_a();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic check_a_idle_outputs(input string tag);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".rv"}, 64'(result_valid), 64'd0);
    check({tag, ".result"}, 64'(result), 64'd0);
    check({tag, ".error"}, 64'(error), 64'd0);
    check({tag, ".t_enable"}, 64'(t_enable), 64'd0);
    check({tag, ".t_addr"}, 64'(t_addr), 64'd0);
    check({tag, ".t_data_in"}, 64'(t_data_in), 64'd0);
    check({tag, ".state"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  int req0, rst0, rv0, base, c1;

  initial begin
    // reset
    tick(3);
    rst = 1'b0;
    check_a_idle_outputs("reset_a");
    check("reset_b.busy", 64'(s_busy), 64'd0);
    check("reset_b.result", 64'(s_result), 64'd0);
    check("reset_b.t_enable", 64'(s_t_enable), 64'd0);
    tick(1);

    // basic measurement: stop 100 cycles after RUN entry
    req0 = req_cnt; rst0 = rst_wr_cnt; rv0 = rv_cnt;
    pulse_start_a();
    check("basic.busy", 64'(busy), 64'd1);
    check("basic.state_rst_req", 64'(state_dbg), 64'(ST_RST_REQ));
    check("basic.rst_en", 64'(t_enable), 64'd1);
    check("basic.rst_addr", 64'(t_addr), 64'd1);
    check("basic.rst_data", 64'(t_data_in), 64'd1);
    tick(2);
    check("basic.run", 64'(state_dbg), 64'(ST_RUN));
    tick(100);
    pulse_stop_a();
    check("basic.fin_req", 64'(state_dbg), 64'(ST_FIN_REQ));
    check("basic.fin_en", 64'(t_enable), 64'd1);
    check("basic.fin_addr", 64'(t_addr), 64'd0);
    tick(1);
    check("basic.rv_early", 64'(result_valid), 64'd0);
    tick(1);
    check("basic.rv", 64'(result_valid), 64'd1);
    check("basic.result", 64'(result), 64'h0067);
    check("basic.busy_low", 64'(busy), 64'd0);
    check("basic.error", 64'(error), 64'd0);
    tick(2);
    check("basic.rv_once", 64'(rv_cnt - rv0), 64'd1);
    check("basic.rst_writes", 64'(rst_wr_cnt - rst0), 64'd1);
    check("basic.requests", 64'(req_cnt - req0), 64'd3);

    // wrap tracking: stop 600 cycles after RUN entry
    base = rd_times.size();
    pulse_start_a();
    c1 = cyc;
    tick(602);
    pulse_stop_a();
    tick(2);
    check("wrap.rv", 64'(result_valid), 64'd1);
    check("wrap.result", 64'(result), 64'h025B);
    check("wrap.error", 64'(error), 64'd0);
    check("wrap.reads", 64'(rd_times.size() - base), 64'd10);
    if (rd_times.size() - base == 10) begin
      check("wrap.first_poll", 64'(rd_times[base] - c1), 64'd66);
      for (int i = 1; i < 9; i++) begin
        check("wrap.poll_gap", 64'(rd_times[base + i] - rd_times[base + i - 1]), 64'd66);
      end
    end
    tick(2);

    // stop in RD_WAIT
    req0 = req_cnt; rv0 = rv_cnt;
    pulse_start_a();
    tick(67);
    check("pollstop.rd_wait", 64'(state_dbg), 64'(ST_RD_WAIT));
    pulse_stop_a();
    check("pollstop.fin_req", 64'(state_dbg), 64'(ST_FIN_REQ));
    check("pollstop.fin_en", 64'(t_enable), 64'd1);
    tick(2);
    check("pollstop.rv", 64'(result_valid), 64'd1);
    check("pollstop.result", 64'(result), 64'h0044);
    tick(3);
    check("pollstop.rv_once", 64'(rv_cnt - rv0), 64'd1);
    check("pollstop.requests", 64'(req_cnt - req0), 64'd3);

    // timeout on the reset write
    ack_en = 1'b0;
    rv0 = rv_cnt;
    pulse_start_a();
    tick(15);
    check("timeout.error_before", 64'(error), 64'd0);
    check("timeout.busy_before", 64'(busy), 64'd1);
    tick(1);
    check("timeout.error", 64'(error), 64'd1);
    check("timeout.busy", 64'(busy), 64'd0);
    check("timeout.state_err", 64'(state_dbg), 64'(ST_ERR));
    tick(1);
    check("timeout.state_idle", 64'(state_dbg), 64'(ST_IDLE));
    tick(2);
    check("timeout.no_rv", 64'(rv_cnt - rv0), 64'd0);
    check("timeout.error_sticky", 64'(error), 64'd1);
    ack_en = 1'b1;
    pulse_start_a();
    check("timeout.restart_clears", 64'(error), 64'd0);
    check("timeout.restart_busy", 64'(busy), 64'd1);

    // ignored inputs: start while busy, reset mid-RUN, stop in IDLE
    tick(9);
    rst0 = rst_wr_cnt; req0 = req_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ignore.start_busy_state", 64'(state_dbg), 64'(ST_RUN));
    check("ignore.start_busy_en", 64'(t_enable), 64'd0);
    tick(2);
    check("ignore.start_busy_writes", 64'(rst_wr_cnt - rst0), 64'd0);
    tick(52);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_a_idle_outputs("ignore.rst_mid_run");
    check("ignore.no_poll_before_rst", 64'(req_cnt - req0), 64'd0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(3);
    check("ignore.stop_idle_req", 64'(req_cnt - req0), 64'd0);
    check("ignore.stop_idle_state", 64'(state_dbg), 64'(ST_IDLE));
    check("ignore.stop_idle_busy", 64'(busy), 64'd0);
    check("bus.no_back_to_back_a", 64'(b2b_cnt), 64'd0);

    // saturation on instance b
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    tick(2);
    check("sat.run", 64'(s_state_dbg), 64'(ST_RUN));
    tick(96);
    s_stop = 1'b1;
    tick(1);
    s_stop = 1'b0;
    tick(2);
    check("sat.rv", 64'(s_result_valid), 64'd1);
    check("sat.result", 64'(s_result), 64'h33);
    check("sat.error", 64'(s_error), 64'd1);
    check("sat.busy", 64'(s_busy), 64'd0);
    tick(2);
    check("sat.rv_once", 64'(s_rv_cnt), 64'd1);
    check("bus.no_back_to_back_b", 64'(s_b2b_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // run-time bound
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
